// File: rtl/conv_window_mac_pkg.sv
// conv_pkg: shared state encoding, default widths and output saturation helper
package conv_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} mac_state_t;
  localparam int ACC_WIDTH_DEF = 40;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/conv_window_mac_weight_buf.sv
// conv_weight_buf: single-write/single-read weight RAM with registered (1-cycle) read
module conv_weight_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int WGT_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int IW = $clog2(WGT_DEPTH);
  logic [DATA_WIDTH-1:0] mem [WGT_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^{waddr[ADDR_WIDTH-1:IW], raddr[ADDR_WIDTH-1:IW]};
  assign rdata = rdata_q;
  // write port and registered read port; contents survive reset by design
  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    rdata_q <= mem[raddr[IW-1:0]];
  end
endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac: window multiply-accumulate with 2-entry output FIFO; CONV_MAC_RELU_EN clamps negatives to 0
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int WGT_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_k_dimension,
  input  logic [ADDR_WIDTH-1:0] cfg_chans,
  input  logic [ADDR_WIDTH-1:0] cfg_o_dimension,
  input  logic [4:0]            cfg_shift,
  input  logic                  wgt_we,
  input  logic [ADDR_WIDTH-1:0] wgt_waddr,
  input  logic [DATA_WIDTH-1:0] wgt_wdata,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_finish,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_row_end,
  output logic                  busy,
  output logic                  overrun
);
  localparam int PW = 2 * DATA_WIDTH;
  mac_state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]         elem_q, elem_d, n_q, n_d, col_q, col_d;
  logic [ADDR_WIDTH-1:0]         n_calc, n_cur;
  logic                          fin_q, abort, take, last;
  logic                          v1_q, v1_d, last1_q, last1_d, v2_q, v2_d, last2_q, last2_d;
  logic signed [DATA_WIDTH-1:0]  d1_q, d1_d, w_rdata;
  logic signed [PW-1:0]          prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, prod_ext, sum, acc_sh;
  logic signed [DATA_WIDTH-1:0]  sat_dw, res_q, res_d;
  logic                          res_v_q, res_v_d;
  logic [DATA_WIDTH:0]           mem_q [2];
  logic [DATA_WIDTH:0]           mem_d [2];
  logic                          wp_q, wp_d, rp_q, rp_d, ovr_q, ovr_d, pop, full, wr, row_end;
  logic [1:0]                    cnt_q, cnt_d;
  conv_weight_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WGT_DEPTH(WGT_DEPTH)) u_wbuf (
    .clk(clk), .we(wgt_we), .waddr(wgt_waddr), .wdata(wgt_wdata), .raddr(elem_q), .rdata(w_rdata)
  );
  assign n_calc   = ADDR_WIDTH'(cfg_k_dimension * cfg_k_dimension * cfg_chans);
  assign n_cur    = state_q == IDLE ? n_calc : n_q;
  assign abort    = in_finish && !fin_q && state_q != IDLE && elem_q != '0;
  assign take     = in_valid && !abort && !(state_q == IDLE && in_finish);
  assign last     = elem_q == n_cur - ADDR_WIDTH'(1);
  assign prod_ext = ACC_WIDTH'(prod_q);
  assign sum      = acc_q + prod_ext;
  assign acc_sh   = sum >>> cfg_shift;
  assign sat_dw   = DATA_WIDTH'(saturate(64'(acc_sh), DATA_WIDTH));
  // window FSM and element counter; the weight address is elem_q so it lines up with d1_q
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    n_d     = n_q;
    if (abort) begin
      state_d = IDLE;
      elem_d  = '0;
    end else if (take) begin
      state_d = last ? FLUSH : ACCUM;
      elem_d  = last ? '0 : elem_q + ADDR_WIDTH'(1);
      n_d     = state_q == IDLE ? n_calc : n_q;
    end else if (state_q == FLUSH) state_d = IDLE;
  end
  // data pipeline: register element, register product, accumulate, then shift/saturate the finished sum
  always_comb begin
    v1_d    = take;
    last1_d = take && last;
    d1_d    = take ? in_data : d1_q;
    v2_d    = v1_q && !abort;
    last2_d = last1_q;
    prod_d  = v1_q ? PW'(d1_q) * PW'(w_rdata) : prod_q;
    acc_d   = abort ? '0 : v2_q ? (last2_q ? '0 : sum) : acc_q;
    res_v_d = v2_q && last2_q;
`ifdef CONV_MAC_RELU_EN
    res_d   = sat_dw[DATA_WIDTH-1] ? '0 : sat_dw;
`else
    res_d   = sat_dw;
`endif
  end
  // output FIFO push/pop, row tagging and sticky overrun
  always_comb begin
    pop     = cnt_q != 2'd0 && out_ready;
    full    = cnt_q == 2'd2;
    wr      = res_v_q && (!full || pop);
    row_end = col_q == cfg_o_dimension - ADDR_WIDTH'(1);
    col_d   = abort ? '0 : res_v_q ? (row_end ? '0 : col_q + ADDR_WIDTH'(1)) : col_q;
    mem_d   = mem_q;
    if (wr) mem_d[wp_q] = {row_end, res_q};
    wp_d    = wp_q ^ wr;
    rp_d    = rp_q ^ pop;
    cnt_d   = cnt_q + 2'(wr) - 2'(pop);
    ovr_d   = ovr_q | (res_v_q && full && !pop);
  end
  assign out_valid                = cnt_q != 2'd0;
  assign {out_row_end, out_data}  = out_valid ? mem_q[rp_q] : '0;
  assign busy                     = state_q != IDLE;
  assign overrun                  = ovr_q;
  // state registers, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      n_q     <= '0;
      col_q   <= '0;
      fin_q   <= 1'b0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      d1_q    <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      res_v_q <= 1'b0;
      res_q   <= '0;
      mem_q   <= '{default: '0};
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      n_q     <= n_d;
      col_q   <= col_d;
      fin_q   <= in_finish;
      v1_q    <= v1_d;
      last1_q <= last1_d;
      d1_q    <= d1_d;
      v2_q    <= v2_d;
      last2_q <= last2_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      res_v_q <= res_v_d;
      res_q   <= res_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: directed self-checking bench for conv_window_mac
module tb_conv_window_mac;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_k_dimension = 16'd3;
  logic [15:0] cfg_chans = 16'd1;
  logic [15:0] cfg_o_dimension = 16'd2;
  logic [4:0]  cfg_shift = 5'd0;
  logic        wgt_we = 1'b0;
  logic [15:0] wgt_waddr = '0;
  logic [15:0] wgt_wdata = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_finish = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_row_end;
  logic        busy;
  logic        overrun;
  int          total = 0;
  int          bad = 0;
  conv_window_mac dut (
    .clk(clk), .rst(rst), .cfg_k_dimension(cfg_k_dimension), .cfg_chans(cfg_chans),
    .cfg_o_dimension(cfg_o_dimension), .cfg_shift(cfg_shift), .wgt_we(wgt_we),
    .wgt_waddr(wgt_waddr), .wgt_wdata(wgt_wdata), .in_valid(in_valid), .in_data(in_data),
    .in_finish(in_finish), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_end(out_row_end), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic load_w(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) begin
      wgt_we = 1'b1;
      wgt_waddr = 16'(i);
      wgt_wdata = v;
      step();
    end
    wgt_we = 1'b0;
  endtask
  task automatic send(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = v;
      step();
    end
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output logic got, output logic [15:0] d, output logic re);
    got = 1'b0;
    d = '0;
    re = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if (out_valid) begin
        got = 1'b1;
        d = out_data;
        re = out_row_end;
      end
    end
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid, out_data, out_row_end, busy, overrun} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h re=%b busy=%b ovr=%b exp all 0", out_valid, out_data, out_row_end, busy, overrun);
    end
  endtask
  task automatic test_basic();
    load_w(9, 16'd1);
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1;
      in_data = 16'(i);
      step();
      if (i == 5) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
      end
    end
    in_valid = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b exp=0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'd45 || out_row_end !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got v=%b d=%0d re=%b exp v=1 d=45 re=0", out_valid, out_data, out_row_end);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_pop got v=%b busy=%b exp 0 0", out_valid, busy); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    load_w(9, 16'd2);
    for (int i = 1; i <= 21; i++) begin
      in_valid = i <= 18;
      in_data = 16'd3;
      step();
      if (i == 12) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'd54 || out_row_end !== 1'b0) begin
          bad++;
          $display("FAIL b2b_first got v=%b d=%0d re=%b exp v=1 d=54 re=0", out_valid, out_data, out_row_end);
        end
      end
      if (i == 13 || i == 20) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap_%0d got=%b exp=0", i, out_valid); end
      end
      if (i == 21) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'd54 || out_row_end !== 1'b1) begin
          bad++;
          $display("FAIL b2b_second got v=%b d=%0d re=%b exp v=1 d=54 re=1", out_valid, out_data, out_row_end);
        end
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic test_arith();
    logic        got;
    logic [15:0] d;
    logic        re;
    logic [15:0] exp_vals [4];
    logic [15:0] wts [4];
    logic [15:0] ins [4];
    logic [4:0]  shs [4];
    wts = '{16'h7FFF, 16'hFFFF, 16'h0001, 16'hFFFF};
    ins = '{16'h7FFF, 16'h7FFF, 16'd100, 16'd10};
    shs = '{5'd0, 5'd0, 5'd2, 5'd0};
`ifdef CONV_MAC_RELU_EN
    exp_vals = '{16'h7FFF, 16'h0000, 16'd225, 16'h0000};
`else
    exp_vals = '{16'h7FFF, 16'h8000, 16'd225, 16'hFFA6};
`endif
    for (int t = 0; t < 4; t++) begin
      do_reset();
      load_w(9, wts[t]);
      cfg_shift = shs[t];
      send(9, ins[t]);
      wait_out(got, d, re);
      total++;
      if (!got || d !== exp_vals[t]) begin
        bad++;
        $display("FAIL arith_%0d got v=%b d=%h exp d=%h", t, got, d, exp_vals[t]);
      end
      step();
    end
    cfg_shift = 5'd0;
  endtask
  task automatic test_overrun();
    do_reset();
    load_w(9, 16'd1);
    out_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      send(9, 16'(j));
      for (int i = 0; i < 5; i++) step();
      if (j == 2) begin
        total++;
        if (overrun !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_two_held got ovr=%b v=%b exp 0 1", overrun, out_valid); end
      end
    end
    total++;
    if (overrun !== 1'b1 || out_data !== 16'd9 || out_row_end !== 1'b0) begin
      bad++;
      $display("FAIL ovr_full got ovr=%b d=%0d re=%b exp 1 9 0", overrun, out_data, out_row_end);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'd18 || out_row_end !== 1'b1) begin
      bad++;
      $display("FAIL ovr_pop2 got v=%b d=%0d re=%b exp 1 18 1", out_valid, out_data, out_row_end);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin bad++; $display("FAIL ovr_drained got v=%b ovr=%b exp 0 1", out_valid, overrun); end
  endtask
  task automatic test_reset_mid();
    logic        got;
    logic [15:0] d;
    logic        re;
    send(5, 16'd1);
    rst = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_clear got busy=%b v=%b ovr=%b exp 0 0 0", busy, out_valid, overrun);
    end
    rst = 1'b0;
    send(9, 16'd2);
    wait_out(got, d, re);
    total++;
    if (!got || d !== 16'd18 || re !== 1'b0) begin bad++; $display("FAIL rstmid_sum got v=%b d=%0d re=%b exp 1 18 0", got, d, re); end
    step();
  endtask
  task automatic test_finish();
    logic        got;
    logic [15:0] d;
    logic        re;
    logic        seen;
    do_reset();
    load_w(9, 16'd1);
    send(9, 16'd1);
    wait_out(got, d, re);
    total++;
    if (!got || d !== 16'd9 || re !== 1'b0) begin bad++; $display("FAIL fin_pre got v=%b d=%0d re=%b exp 1 9 0", got, d, re); end
    send(4, 16'd1);
    in_finish = 1'b1;
    step();
    in_finish = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen |= out_valid;
    end
    total++;
    if (seen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL fin_discard got seen=%b busy=%b exp 0 0", seen, busy); end
    in_finish = 1'b1;
    step();
    send(9, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= out_valid | busy;
    end
    in_finish = 1'b0;
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL fin_idle_ignore got=%b exp=0", seen); end
    send(9, 16'd1);
    wait_out(got, d, re);
    total++;
    if (!got || d !== 16'd9 || re !== 1'b0) begin bad++; $display("FAIL fin_post1 got v=%b d=%0d re=%b exp 1 9 0", got, d, re); end
    send(9, 16'd1);
    wait_out(got, d, re);
    total++;
    if (!got || d !== 16'd9 || re !== 1'b1) begin bad++; $display("FAIL fin_post2 got v=%b d=%0d re=%b exp 1 9 1", got, d, re); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_arith();
    test_overrun();
    test_reset_mid();
    test_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
